// File: rtl/angle_div_seq_if.sv
// Operand/result handshake bundle for the angle-path divider.
// The slave side is the divider; the master side is the angle accumulator
// (operands) and the LUT/CORDIC stage (results).
interface angle_div_seq_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int FRAC_W     = 8
);
    logic                         val_i;
    logic                         rdy_o;
    logic [DIVIDEND_W-1:0]        dividend;
    logic [DIVISOR_W-1:0]         divisor;
    logic                         val_o;
    logic                         rdy_i;
    logic [DIVIDEND_W+FRAC_W-1:0] quot;
    logic [DIVISOR_W-1:0]         rem;
    logic                         div_zero;
    logic                         ovf;

    modport slave (
        input  val_i, dividend, divisor, rdy_i,
        output rdy_o, val_o, quot, rem, div_zero, ovf
    );

    modport master (
        output val_i, dividend, divisor, rdy_i,
        input  rdy_o, val_o, quot, rem, div_zero, ovf
    );
endinterface

// File: rtl/angle_div_seq.sv
// Radix-2 restoring divider for the angle-calculation path.
// Quotient is fixed point with FRAC_W fractional bits; one quotient bit per
// clock. Signed mode divides magnitudes and fixes up signs at the end.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | rdy_o high, waiting for an operand pair
// CALC  | one restoring step per clock, counter runs Q-1 down to 0
// DONE  | result presented with val_o, held until rdy_i
module angle_div_seq #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int FRAC_W     = 8,
    parameter int SIGNED     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    angle_div_seq_if.slave   bus
);

    localparam int Q     = DIVIDEND_W + FRAC_W;
    localparam int CNT_W = $clog2(Q + 1);

    localparam logic [Q-1:0] MAX_POS  = {1'b0, {(Q-1){1'b1}}};
    localparam logic [Q-1:0] MIN_NEG  = {1'b1, {(Q-1){1'b0}}};
    localparam logic [Q-1:0] ALL_ONES = {Q{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  alive_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [Q-1:0]          num_q, num_d;
    logic [DIVISOR_W:0]    prem_q, prem_d;
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
    logic                  qsign_q, qsign_d;
    logic                  rsign_q, rsign_d;
    logic [Q-1:0]          quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;

    logic                  rdy;
    logic                  dvd_neg, dvs_neg;
    logic [DIVIDEND_W-1:0] dvd_mag;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic [Q-1:0]          dz_quot;

    logic [DIVISOR_W:0]    trial;
    logic                  ge;
    logic [DIVISOR_W:0]    step_rem;
    logic [Q-1:0]          step_num;

    logic [Q-1:0]          qmag;
    logic [DIVISOR_W-1:0]  rmag;
    logic [Q-1:0]          res_quot;
    logic [DIVISOR_W-1:0]  res_rem;
    logic                  res_ovf;

    assign rdy          = alive_q && (state_q == IDLE);
    assign bus.rdy_o    = rdy;
    assign bus.val_o    = (state_q == DONE);
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
    assign bus.div_zero = dz_q;
    assign bus.ovf      = ovf_q;

    // Operand magnitudes and signs; a zero divisor short-circuits to a saturated quotient
    always_comb begin
        dvd_neg = (SIGNED != 0) && bus.dividend[DIVIDEND_W-1];
        dvs_neg = (SIGNED != 0) && bus.divisor[DIVISOR_W-1];
        dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag = dvs_neg ? -bus.divisor : bus.divisor;
        if (SIGNED != 0) begin
            dz_quot = dvd_neg ? MIN_NEG : MAX_POS;
        end else begin
            dz_quot = ALL_ONES;
        end
    end

    // One restoring step; prem_q MSB acts as the carry out of the shifted remainder
    always_comb begin
        trial    = {prem_q[DIVISOR_W-1:0], num_q[Q-1]};
        ge       = prem_q[DIVISOR_W] || (trial >= {1'b0, dvsr_q});
        step_rem = ge ? (trial - {1'b0, dvsr_q}) : trial;
        step_num = {num_q[Q-2:0], ge};
    end

    // Sign fix-up and saturation applied to the result of the final step
    always_comb begin
        qmag     = step_num;
        rmag     = step_rem[DIVISOR_W-1:0];
        res_quot = qmag;
        res_rem  = rmag;
        res_ovf  = 1'b0;
        if (SIGNED != 0) begin
            if (qsign_q ? (qmag > MIN_NEG) : qmag[Q-1]) begin
                res_quot = qsign_q ? MIN_NEG : MAX_POS;
                res_rem  = '0;
                res_ovf  = 1'b1;
            end else begin
                res_quot = qsign_q ? -qmag : qmag;
                res_rem  = rsign_q ? -rmag : rmag;
            end
        end
    end

    // Next-state and datapath load decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        prem_d  = prem_q;
        dvsr_d  = dvsr_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.val_i && rdy) begin
                    qsign_d = dvd_neg ^ dvs_neg;
                    rsign_d = dvd_neg;
                    dvsr_d  = dvs_mag;
                    num_d   = Q'(dvd_mag) << FRAC_W;
                    prem_d  = '0;
                    if (bus.divisor == '0) begin
                        quot_d  = dz_quot;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(Q - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                num_d  = step_num;
                prem_d = step_rem;
                if (cnt_q == '0) begin
                    quot_d  = res_quot;
                    rem_d   = res_rem;
                    dz_d    = 1'b0;
                    ovf_d   = res_ovf;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any divide in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
            cnt_q   <= '0;
            num_q   <= '0;
            prem_q  <= '0;
            dvsr_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            prem_q  <= prem_d;
            dvsr_q  <= dvsr_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_angle_div_seq.sv
// Directed bench for angle_div_seq: an unsigned and a signed instance share
// clock and reset; sel picks which one the stimulus tasks talk to.
module tb_angle_div_seq;

    logic clk;
    logic rst_n;
    logic sel;
    int   nvec;
    int   nerr;

    angle_div_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8), .FRAC_W(8)) bus_u ();
    angle_div_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8), .FRAC_W(8)) bus_s ();

    angle_div_seq #(.DIVIDEND_W(16), .DIVISOR_W(8), .FRAC_W(8), .SIGNED(0)) u_uns (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_u)
    );

    angle_div_seq #(.DIVIDEND_W(16), .DIVISOR_W(8), .FRAC_W(8), .SIGNED(1)) u_sgn (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    logic        obs_val, obs_rdy, obs_dz, obs_ovf;
    logic [23:0] obs_quot;
    logic [7:0]  obs_rem;

    assign obs_val  = sel ? bus_s.val_o    : bus_u.val_o;
    assign obs_rdy  = sel ? bus_s.rdy_o    : bus_u.rdy_o;
    assign obs_dz   = sel ? bus_s.div_zero : bus_u.div_zero;
    assign obs_ovf  = sel ? bus_s.ovf      : bus_u.ovf;
    assign obs_quot = sel ? bus_s.quot     : bus_u.quot;
    assign obs_rem  = sel ? bus_s.rem      : bus_u.rem;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one operand pair at a negedge; returns at the negedge after the accept edge
    task automatic start_op(input logic s, input logic [15:0] dvd, input logic [7:0] dvs);
        sel = s;
        if (s) begin
            bus_s.dividend = dvd;
            bus_s.divisor  = dvs;
            bus_s.val_i    = 1'b1;
        end else begin
            bus_u.dividend = dvd;
            bus_u.divisor  = dvs;
            bus_u.val_i    = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus_s.val_i = 1'b0;
        bus_u.val_i = 1'b0;
    endtask

    // Cycles from the accept edge until val_o is seen; -1 if it never comes
    task automatic wait_val(output int lat);
        lat = 0;
        while (!obs_val && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!obs_val) lat = -1;
    endtask

    task automatic ack();
        if (sel) bus_s.rdy_i = 1'b1; else bus_u.rdy_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_s.rdy_i = 1'b0;
        bus_u.rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            nvec++;
            if ({obs_rdy, obs_val, obs_dz, obs_ovf} !== 4'b0000) begin
                $display("FAIL reset_flags sel=%0d: got %b want 0000", s, {obs_rdy, obs_val, obs_dz, obs_ovf});
                nerr++;
            end
            nvec++;
            if (obs_quot !== 24'h0 || obs_rem !== 8'h0) begin
                $display("FAIL reset_data sel=%0d: got quot=%h rem=%h want 000000/00", s, obs_quot, obs_rem);
                nerr++;
            end
        end
        rst_n = 1'b1;
        sel = 1'b0;
        #1;
        nvec++;
        if (obs_rdy !== 1'b0) begin
            $display("FAIL rdy_before_edge: got %b want 0", obs_rdy);
            nerr++;
        end
        @(negedge clk);
        nvec++;
        if (bus_u.rdy_o !== 1'b1 || bus_s.rdy_o !== 1'b1) begin
            $display("FAIL rdy_after_edge: got %b%b want 11", bus_u.rdy_o, bus_s.rdy_o);
            nerr++;
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] dvd [4];
        logic [7:0]  dvs [4];
        logic [23:0] eq  [4];
        logic [7:0]  er  [4];
        int lat;
        dvd = '{16'd1000, 16'd255, 16'hFFFF, 16'd1};
        dvs = '{8'd7, 8'd5, 8'd1, 8'd3};
        eq  = '{24'h008EDB, 24'h003300, 24'hFFFF00, 24'h000055};
        er  = '{8'd3, 8'd0, 8'd0, 8'd1};
        for (int i = 0; i < 4; i++) begin
            start_op(1'b0, dvd[i], dvs[i]);
            wait_val(lat);
            nvec++;
            if (lat !== 24) begin
                $display("FAIL u_latency[%0d]: got %0d want 24", i, lat);
                nerr++;
            end
            nvec++;
            if (obs_quot !== eq[i] || obs_rem !== er[i]) begin
                $display("FAIL u_result[%0d]: got quot=%h rem=%h want %h/%h", i, obs_quot, obs_rem, eq[i], er[i]);
                nerr++;
            end
            nvec++;
            if ({obs_dz, obs_ovf} !== 2'b00) begin
                $display("FAIL u_flags[%0d]: got %b want 00", i, {obs_dz, obs_ovf});
                nerr++;
            end
            ack();
        end
    endtask

    task automatic test_signed();
        logic [15:0] dvd [6];
        logic [7:0]  dvs [6];
        logic [23:0] eq  [6];
        logic [7:0]  er  [6];
        int lat;
        dvd = '{16'hFC18, 16'd1000, 16'hFC18, 16'h8000, 16'h8000, 16'h7FFF};
        dvs = '{8'd7, 8'hF9, 8'hF9, 8'd2, 8'd1, 8'hFF};
        eq  = '{24'hFF7125, 24'hFF7125, 24'h008EDB, 24'hC00000, 24'h800000, 24'h800100};
        er  = '{8'hFD, 8'h03, 8'hFD, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            start_op(1'b1, dvd[i], dvs[i]);
            wait_val(lat);
            nvec++;
            if (lat !== 24) begin
                $display("FAIL s_latency[%0d]: got %0d want 24", i, lat);
                nerr++;
            end
            nvec++;
            if (obs_quot !== eq[i] || obs_rem !== er[i]) begin
                $display("FAIL s_result[%0d]: got quot=%h rem=%h want %h/%h", i, obs_quot, obs_rem, eq[i], er[i]);
                nerr++;
            end
            nvec++;
            if ({obs_dz, obs_ovf} !== 2'b00) begin
                $display("FAIL s_flags[%0d]: got %b want 00", i, {obs_dz, obs_ovf});
                nerr++;
            end
            ack();
        end
    endtask

    task automatic test_div_zero();
        logic        s   [3];
        logic [15:0] dvd [3];
        logic [23:0] eq  [3];
        int lat;
        s   = '{1'b0, 1'b1, 1'b1};
        dvd = '{16'h1234, 16'hFFFB, 16'd5};
        eq  = '{24'hFFFFFF, 24'h800000, 24'h7FFFFF};
        for (int i = 0; i < 3; i++) begin
            start_op(s[i], dvd[i], 8'h00);
            wait_val(lat);
            nvec++;
            if (lat !== 0) begin
                $display("FAIL dz_latency[%0d]: got %0d want 0", i, lat);
                nerr++;
            end
            nvec++;
            if (obs_quot !== eq[i] || obs_rem !== 8'h00) begin
                $display("FAIL dz_result[%0d]: got quot=%h rem=%h want %h/00", i, obs_quot, obs_rem, eq[i]);
                nerr++;
            end
            nvec++;
            if ({obs_dz, obs_ovf} !== 2'b10) begin
                $display("FAIL dz_flags[%0d]: got %b want 10", i, {obs_dz, obs_ovf});
                nerr++;
            end
            ack();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] dvs [2];
        int lat;
        dvs = '{8'hFF, 8'h01};
        for (int i = 0; i < 2; i++) begin
            start_op(1'b1, 16'h8000 ^ {15'h0, i[0]} ^ {15'h0, i[0]}, dvs[i]);
            wait_val(lat);
            nvec++;
            if (lat !== 24) begin
                $display("FAIL ovf_latency[%0d]: got %0d want 24", i, lat);
                nerr++;
            end
            nvec++;
            if (obs_quot !== (i == 0 ? 24'h7FFFFF : 24'h800000) || obs_rem !== 8'h00) begin
                $display("FAIL ovf_result[%0d]: got quot=%h rem=%h", i, obs_quot, obs_rem);
                nerr++;
            end
            nvec++;
            if ({obs_dz, obs_ovf} !== (i == 0 ? 2'b01 : 2'b00)) begin
                $display("FAIL ovf_flags[%0d]: got %b want %b", i, {obs_dz, obs_ovf}, (i == 0 ? 2'b01 : 2'b00));
                nerr++;
            end
            ack();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        sel = 1'b0;
        bus_u.rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if ({obs_val, obs_rdy} !== 2'b01) begin
                $display("FAIL idle_rdy_i[%0d]: got %b want 01", i, {obs_val, obs_rdy});
                nerr++;
            end
        end
        bus_u.rdy_i = 1'b0;
        start_op(1'b0, 16'd1000, 8'd7);
        wait_val(lat);
        nvec++;
        if (lat !== 24) begin
            $display("FAIL bp_latency: got %0d want 24", lat);
            nerr++;
        end
        for (int i = 0; i < 10; i++) begin
            bus_u.val_i    = 1'b1;
            bus_u.dividend = 16'(50 + i);
            bus_u.divisor  = 8'd3;
            @(negedge clk);
            nvec++;
            if ({obs_val, obs_rdy, obs_dz, obs_quot, obs_rem} !== {3'b100, 24'h008EDB, 8'd3}) begin
                $display("FAIL bp_hold[%0d]: got val=%b rdy=%b quot=%h rem=%h", i, obs_val, obs_rdy, obs_quot, obs_rem);
                nerr++;
            end
        end
        bus_u.val_i = 1'b0;
        ack();
        nvec++;
        if ({obs_val, obs_rdy} !== 2'b01) begin
            $display("FAIL bp_release: got %b want 01", {obs_val, obs_rdy});
            nerr++;
        end
        @(negedge clk);
        nvec++;
        if ({obs_val, obs_rdy} !== 2'b01) begin
            $display("FAIL bp_no_queue: got %b want 01", {obs_val, obs_rdy});
            nerr++;
        end
        start_op(1'b0, 16'd255, 8'd5);
        wait_val(lat);
        nvec++;
        if (lat !== 24 || obs_quot !== 24'h003300 || obs_rem !== 8'h00) begin
            $display("FAIL bp_next: got lat=%0d quot=%h rem=%h want 24/003300/00", lat, obs_quot, obs_rem);
            nerr++;
        end
        ack();
    endtask

    task automatic test_reset_abort();
        int lat;
        start_op(1'b0, 16'd1000, 8'd7);
        repeat (12) @(negedge clk);
        nvec++;
        if (obs_val !== 1'b0 || obs_quot !== 24'h003300) begin
            $display("FAIL abort_pre: got val=%b quot=%h want 0/003300", obs_val, obs_quot);
            nerr++;
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({bus_u.rdy_o, bus_u.val_o, bus_u.div_zero, bus_u.ovf, bus_u.quot, bus_u.rem} !== 36'h0) begin
            $display("FAIL abort_uns: got rdy=%b val=%b quot=%h rem=%h want all 0", bus_u.rdy_o, bus_u.val_o, bus_u.quot, bus_u.rem);
            nerr++;
        end
        nvec++;
        if ({bus_s.rdy_o, bus_s.val_o, bus_s.div_zero, bus_s.ovf, bus_s.quot, bus_s.rem} !== 36'h0) begin
            $display("FAIL abort_sgn: got rdy=%b val=%b quot=%h rem=%h want all 0", bus_s.rdy_o, bus_s.val_o, bus_s.quot, bus_s.rem);
            nerr++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if ({obs_val, obs_rdy} !== 2'b01) begin
            $display("FAIL abort_recover: got %b want 01", {obs_val, obs_rdy});
            nerr++;
        end
        start_op(1'b0, 16'd255, 8'd5);
        wait_val(lat);
        nvec++;
        if (lat !== 24 || obs_quot !== 24'h003300 || obs_rem !== 8'h00 || obs_dz !== 1'b0) begin
            $display("FAIL abort_fresh: got lat=%0d quot=%h rem=%h dz=%b want 24/003300/00/0", lat, obs_quot, obs_rem, obs_dz);
            nerr++;
        end
        ack();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        sel  = 1'b0;
        bus_u.val_i = 1'b0; bus_u.rdy_i = 1'b0; bus_u.dividend = '0; bus_u.divisor = '0;
        bus_s.val_i = 1'b0; bus_s.rdy_i = 1'b0; bus_s.dividend = '0; bus_s.divisor = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
